// File: rtl/dt_traverse_ctrl.sv
// Decision-tree walk sequencer: node fetch, feature select, comparator issue.
// Optional depth guard enabled by defining DT_DEPTH_GUARD_EN.
module dt_traverse_ctrl #(
  parameter int ADDR_W    = 10,
  parameter int FIDX_W    = 5,
  parameter int CLASS_W   = 4,
  parameter int MAX_DEPTH = 31,
  parameter int NODE_W    = 1 + FIDX_W + 27 + 2 * ADDR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [CLASS_W-1:0] class_out,
  output logic [5:0]         depth_out,
  output logic               err,
  output logic               node_rd_en,
  output logic [ADDR_W-1:0]  node_addr,
  input  logic [NODE_W-1:0]  node_data,
  output logic [FIDX_W-1:0]  feat_idx,
  input  logic [31:0]        feat_data,
  output logic               cmp_valid_in,
  output logic [31:0]        cmp_feature,
  output logic [26:0]        cmp_threshold,
  input  logic               cmp_go_left,
  input  logic               cmp_valid_out
);

  localparam int LeftLsb = ADDR_W;
  localparam int ThrLsb  = 2 * ADDR_W;
  localparam int FidxLsb = ThrLsb + 27;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_CMP,
    S_WAIT,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [ADDR_W-1:0]    left_q, left_d;
  logic [ADDR_W-1:0]    right_q, right_d;
  logic [5:0]           depth_q, depth_d;
  logic [5:0]           dout_q, dout_d;
  logic [CLASS_W-1:0]   class_q, class_d;
  logic [31:0]          feat_q, feat_d;
  logic [26:0]          thr_q, thr_d;
  logic                 err_q, err_d;

  logic                 n_leaf;
  logic [FIDX_W-1:0]    n_fidx;
  logic [26:0]          n_thr;
  logic [ADDR_W-1:0]    n_left;
  logic [ADDR_W-1:0]    n_right;

  assign n_leaf  = node_data[NODE_W-1];
  assign n_fidx  = node_data[FidxLsb +: FIDX_W];
  assign n_thr   = node_data[ThrLsb +: 27];
  assign n_left  = node_data[LeftLsb +: ADDR_W];
  assign n_right = node_data[ADDR_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      left_q  <= '0;
      right_q <= '0;
      depth_q <= '0;
      dout_q  <= '0;
      class_q <= '0;
      feat_q  <= '0;
      thr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      left_q  <= left_d;
      right_q <= right_d;
      depth_q <= depth_d;
      dout_q  <= dout_d;
      class_q <= class_d;
      feat_q  <= feat_d;
      thr_q   <= thr_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    left_d  = left_q;
    right_d = right_q;
    depth_d = depth_q;
    dout_d  = dout_q;
    class_d = class_q;
    feat_d  = feat_q;
    thr_d   = thr_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = '0;
          depth_d = '0;
          err_d   = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        if (n_leaf) begin
          class_d = n_thr[CLASS_W-1:0];
          state_d = S_DONE;
        end else begin
          feat_d  = feat_data;
          thr_d   = n_thr;
          left_d  = n_left;
          right_d = n_right;
          depth_d = depth_q + 6'd1;
          state_d = S_CMP;
`ifdef DT_DEPTH_GUARD_EN
          // Runaway walk (e.g. a child loop): abort with a null class.
          if (depth_q == 6'(MAX_DEPTH)) begin
            feat_d  = feat_q;
            thr_d   = thr_q;
            left_d  = left_q;
            right_d = right_q;
            depth_d = depth_q;
            err_d   = 1'b1;
            class_d = '0;
            state_d = S_DONE;
          end
`endif
        end
      end
      S_CMP: state_d = S_WAIT;
      S_WAIT: begin
        if (cmp_valid_out) begin
          addr_d  = cmp_go_left ? left_q : right_q;
          state_d = S_FETCH;
        end
      end
      S_DONE: begin
        dout_d  = depth_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign node_rd_en    = (state_q == S_FETCH);
  assign node_addr     = addr_q;
  assign feat_idx      = (state_q == S_DECODE) ? n_fidx : '0;
  assign cmp_valid_in  = (state_q == S_CMP);
  assign cmp_feature   = feat_q;
  assign cmp_threshold = thr_q;
  assign class_out     = class_q;
  assign depth_out     = dout_q;

`ifdef DT_DEPTH_GUARD_EN
  assign err = err_q;
`else
  assign err = 1'b0;
  logic unused_err;
  assign unused_err = err_q ^ err_d;
`endif

endmodule

// File: doc/dt_traverse_ctrl.md
# dt_traverse_ctrl

Sequencing controller for decision-tree inference. It walks a node memory from the root, fetches the feature selected by each internal node, and drives the shared 27-bit-threshold comparator. It takes the go-left result to pick the child and stops at a leaf, where it reports the class. It sits between the CAN feature register bank, the tree node ROM and the threshold comparator stage.

## Interface
- ADDR_W, 10, node memory address width; root is address 0
- FIDX_W, 5, feature index width (up to 32 features)
- CLASS_W, 4, class label width
- MAX_DEPTH, 31, internal-node limit per inference (guard only)
- NODE_W, derived = 1+FIDX_W+27+2*ADDR_W, node word width
- clk  in  1  clock, all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request inference; accepted only in IDLE
- busy  out  1  high from the cycle after accept until done
- done  out  1  one-cycle pulse when the result is valid
- class_out  out  CLASS_W  leaf class; held until the next done
- depth_out  out  6  internal nodes visited in the last inference
- err  out  1  depth overflow flag (see Configuration)
- node_rd_en  out  1  node memory read strobe
- node_addr  out  ADDR_W  node memory address
- node_data  in  NODE_W  node word, valid the cycle after node_rd_en
- feat_idx  out  FIDX_W  feature select to the register bank (combinational)
- feat_data  in  32  selected feature value (combinational return)
- cmp_valid_in  out  1  comparator issue strobe
- cmp_feature  out  32  registered feature value
- cmp_threshold  out  27  registered threshold
- cmp_go_left  in  1  comparator result
- cmp_valid_out  in  1  comparator result strobe

## Operation
- Node word, MSB first: leaf[NODE_W-1], fidx, threshold[26:0], left, right. In a leaf, the class is threshold[CLASS_W-1:0]; the other fields are ignored.
- States: IDLE, FETCH, DECODE, CMP, WAIT, DONE.
- IDLE: on start, cur_addr←0, depth←0, err←0; go to FETCH.
- FETCH: node_rd_en=1, node_addr=cur_addr; go to DECODE.
- DECODE: node_data is valid.
  - If leaf: class_out←class; go to DONE.
  - If internal: feat_idx=fidx, cmp_feature←feat_data, cmp_threshold←threshold, latch left/right, depth←depth+1; go to CMP.
- CMP: cmp_valid_in=1 for exactly one cycle; go to WAIT.
- WAIT: hold until cmp_valid_out=1, then cur_addr←(cmp_go_left ? left : right) and go to FETCH. No timeout; a stalled comparator holds busy.
- DONE: done=1, depth_out←depth; go to IDLE.
- start while busy is ignored and not queued. start in the DONE cycle is ignored.
- Child addresses are used unmodified; no range check. A self-loop is caught only by the depth guard.

## Timing
- Reset values: busy=0, done=0, class_out=0, depth_out=0, err=0, node_rd_en=0, node_addr=0, feat_idx=0, cmp_valid_in=0, cmp_feature=0, cmp_threshold=0; state=IDLE.
- Node memory latency is fixed at 1 cycle. The comparator returns cmp_valid_out the cycle after cmp_valid_in.
- Each internal node costs 4 cycles: FETCH, DECODE, CMP, WAIT. A leaf costs 2 cycles: FETCH, DECODE.
- With D internal nodes on the path and start accepted in cycle 0, done pulses in cycle 4·D+3. A root leaf gives done at cycle 3.
- busy is high from cycle 1 through the done cycle inclusive.
- Asserting rst_n low mid-inference aborts the walk immediately and restores all reset values; no done is produced.

## Configuration
- DT_DEPTH_GUARD_EN defined:
  - In DECODE of an internal node with depth==MAX_DEPTH, set err←1, class_out←0, and go to DONE. done still pulses.
  - err holds until the next accepted start.
- DT_DEPTH_GUARD_EN undefined: no depth check. err is tied 0. depth wraps modulo 64 and is reported as is.

## Test plan
- Root is a leaf with class 5. start → done at cycle 3, class_out=5, depth_out=0, cmp_valid_in never asserted.
- 3-level tree; node0 fidx=2, thr=1000; feature2=1000. → go_left taken (equal counts as left), visits left subtree, done at cycle 4·D+3 with the expected class.
- Same tree with feature2=1001. → right child path taken, matching class, cmp_threshold=1000 and cmp_feature=1001 during the node0 issue.
- Comparator model delays cmp_valid_out by 5 cycles. → controller waits in WAIT, done delayed by exactly 4 cycles versus nominal, single cmp_valid_in pulse per node.
- Node0 left child = 0, self-loop, with the guard enabled and MAX_DEPTH=31. → done with err=1, class_out=0 at cycle 4·31+3=127. start again at cycle 127 (the DONE cycle) is ignored.
- start pulsed while busy, then rst_n low during WAIT. → no extra inference is queued, all outputs return to reset values asynchronously, and a fresh start completes normally.
